// File: rtl/mips_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents:
//   - register offsets, taken from Adr[3:2]
//   - STATUS bit positions
//   - serial FSM state encoding
//   - a helper that keeps the bit divisor from reaching zero
package mips_mmio_pkg;

  // Register offsets within the 16-byte window (word index, Adr[3:2]).
  localparam logic [1:0] OFF_TXDATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV  = 2'd2;
  localparam logic [1:0] OFF_RESERVED = 2'd3;

  // STATUS layout.
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  // Serial engine state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_STOP  = S_STOP
  } tx_state_e;

  // A divisor of zero would make a bit last forever, so it is stored as 1.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead output.
// dout always presents the oldest entry, so a pop consumes the word that
// is already visible on dout.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (flushes the FIFO)
//   push, din   - write request and data; dropped when full unless a pop
//                 happens at the same edge
//   pop         - consume the head entry; ignored when empty
//   dout        - head entry (show-ahead)
//   full, empty - occupancy flags
//   count       - number of stored entries
module sync_fifo #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WORD_LENGTH-1:0] din,
  output logic [WORD_LENGTH-1:0] dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_LENGTH-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic                   do_push;
  logic                   do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A pop at the same edge frees the slot, so a push while full is still
  // accepted in that case.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage carries no reset; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the processor load/store port.
// Register map, relative to BASE_ADDRESS:
//   0x0  TXDATA   write pushes WD[7:0] into the TX FIFO; reads 0
//   0x4  STATUS   busy/full/empty/overflow plus FIFO count in [15:8];
//                 writing WD[3]=1 clears the sticky overflow bit
//   0x8  BAUDDIV  clock cycles per serial bit, 16 bits; 0 is stored as 1
//   0xC  reserved
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   Adr, WD, WE - byte address, store data and store strobe
//   RD          - combinational load data, 0 outside the window
//   tx          - serial output, idles high
//   tx_busy     - high while a frame is on the line
module mmio_uart_tx
  import mips_mmio_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 'h1001_0000,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [15:0]           DIV_RESET    = 16'd16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Adr,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  WE,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic       sel;
  logic [1:0] offset;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_bauddiv;

  assign sel        = (Adr[ADDR_WIDTH-1:4] == BASE_ADDRESS[ADDR_WIDTH-1:4]);
  assign offset     = Adr[3:2];
  assign wr_txdata  = WE & sel & (offset == OFF_TXDATA);
  assign wr_status  = WE & sel & (offset == OFF_STATUS);
  assign wr_bauddiv = WE & sel & (offset == OFF_BAUDDIV);

  // Byte lanes and upper store bits play no part in this block.
  logic unused_bits;
  assign unused_bits = ^{Adr[1:0], WD[DATA_WIDTH-1:16]};

  // FIFO
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  sync_fifo #(
    .WORD_LENGTH(8),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (wr_txdata),
    .pop  (fifo_pop),
    .din  (WD[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Register bank
  logic [15:0] bauddiv_reg;
  logic        overflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      bauddiv_reg  <= DIV_RESET;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_bauddiv) begin
        bauddiv_reg <= clamp_div(WD[15:0]);
      end
      // A push is lost only when full and the engine is not popping.
      if (wr_status && WD[STAT_OVERFLOW]) begin
        overflow_reg <= 1'b0;
      end else if (wr_txdata && fifo_full && !fifo_pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Serial engine
  tx_state_e   state_reg, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [15:0] div_reg, div_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic        tx_reg, tx_next;
  logic        bit_done;
  logic        load_frame;

  // div_reg is latched at frame start, so BAUDDIV writes only affect
  // later frames.
  assign bit_done = (cnt_reg == div_reg - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      div_reg     <= DIV_RESET;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      div_reg     <= div_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  // tx_next is the line level for the state being entered, which keeps
  // tx and tx_busy aligned on the same edge.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    div_next     = div_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    tx_next      = tx_reg;
    fifo_pop     = 1'b0;
    load_frame   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          load_frame = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = ST_DATA;
          tx_next      = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase

    if (load_frame) begin
      fifo_pop     = 1'b1;
      shift_next   = fifo_dout;
      div_next     = bauddiv_reg;
      cnt_next     = '0;
      bit_idx_next = '0;
      state_next   = ST_START;
      tx_next      = 1'b0;
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != ST_IDLE);

  // Load data
  always_comb begin
    RD = '0;
    if (sel) begin
      case (offset)
        OFF_STATUS: begin
          RD[STAT_BUSY]               = tx_busy;
          RD[STAT_FULL]               = fifo_full;
          RD[STAT_EMPTY]              = fifo_empty;
          RD[STAT_OVERFLOW]           = overflow_reg;
          RD[STAT_COUNT_LSB +: 8]     = 8'(fifo_count);
        end
        OFF_BAUDDIV:  RD[15:0] = bauddiv_reg;
        OFF_TXDATA:   RD = '0;
        OFF_RESERVED: RD = '0;
        default:      RD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX  = 32'h1001_0000;
  localparam logic [31:0] A_ST  = 32'h1001_0004;
  localparam logic [31:0] A_BD  = 32'h1001_0008;
  localparam logic [31:0] A_RSV = 32'h1001_000C;
  localparam logic [31:0] A_OUT = 32'h1001_0010;

  logic        clk;
  logic        reset;
  logic [31:0] Adr;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        tx;
  logic        tx_busy;

  int n_checks;
  int n_fail;

  mmio_uart_tx #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .BASE_ADDRESS(32'h1001_0000),
    .FIFO_DEPTH  (4),
    .DIV_RESET   (16'd16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Adr    (Adr),
    .WD     (WD),
    .WE     (WE),
    .RD     (RD),
    .tx     (tx),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level of a frame bit: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Store launched on the falling edge, taken at the next rising edge;
  // returns 1 ns after that edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Adr = a; WD = d; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0; Adr = 32'h0; WD = 32'h0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Adr = a;
    #1;
    d = RD;
    Adr = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lows;
    apply_reset();
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h4); end
    bus_read(A_BD, d);
    n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL reset_bauddiv: got %h expected %h", d, 32'h10); end
    bus_read(A_TX, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_txdata_read: got %h expected 0", d); end
    bus_read(A_RSV, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reserved_read: got %h expected 0", d); end
    bus_read(A_OUT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL outside_window: got %h expected 0", d); end
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL reset_idle_line: got %0d active cycles expected 0", lows); end
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic exp;
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'hA5);
    // After the push edge the byte is queued but not yet taken.
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL frame_pre_start: got tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy); end
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL frame_status_queued: got %h expected %h", d, 32'h0000_0100); end
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      exp = frame_bit(8'hA5, t / 4);
      n_checks++; if (tx !== exp || tx_busy !== 1'b1) begin n_fail++; $display("FAIL frame_a5_cycle%0d: got tx=%b busy=%b expected tx=%b busy=1", t, tx, tx_busy, exp); end
    end
    @(posedge clk); #1;
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL frame_a5_end: got tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy); end
    $display("test_single_frame done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0] bytes [3];
    logic exp;
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    bus_write(A_BD, 32'd2);
    bus_write(A_TX, 32'h41);
    bus_write(A_TX, 32'h42);
    bus_write(A_TX, 32'h43);
    // t counts cycles after the edge that started the first frame.
    for (int t = 1; t < 60; t++) begin
      if (t > 1) begin @(posedge clk); #1; end
      exp = frame_bit(bytes[t / 20], (t % 20) / 2);
      n_checks++; if (tx !== exp || tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_cycle%0d: got tx=%b busy=%b expected tx=%b busy=1", t, tx, tx_busy, exp); end
      if (t == 1) begin
        bus_read(A_ST, d);
        n_checks++; if (d !== 32'h0000_0201) begin n_fail++; $display("FAIL b2b_status_t1: got %h expected %h", d, 32'h0000_0201); end
      end
      if (t == 20) begin
        bus_read(A_ST, d);
        n_checks++; if (d !== 32'h0000_0101) begin n_fail++; $display("FAIL b2b_status_t20: got %h expected %h", d, 32'h0000_0101); end
      end
      if (t == 40) begin
        bus_read(A_ST, d);
        n_checks++; if (d !== 32'h0000_0005) begin n_fail++; $display("FAIL b2b_status_t40: got %h expected %h", d, 32'h0000_0005); end
      end
    end
    @(posedge clk); #1;
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h0000_0004 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got status=%h busy=%b expected status=%h busy=0", d, tx_busy, 32'h4); end
    $display("test_back_to_back done");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bus_write(A_BD, 32'd100);
    for (int i = 0; i < 6; i++) bus_write(A_TX, 32'h11 + i);
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h0000_040B) begin n_fail++; $display("FAIL ovf_status: got %h expected %h", d, 32'h0000_040B); end
    // Clear through an unaligned alias of STATUS; low address bits are ignored.
    bus_write(32'h1001_0007, 32'h8);
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h0000_0403) begin n_fail++; $display("FAIL ovf_clear: got %h expected %h", d, 32'h0000_0403); end
    bus_write(A_RSV, 32'hFFFF_FFFF);
    bus_read(A_RSV, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reserved_write: got %h expected 0", d); end
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h0000_0403) begin n_fail++; $display("FAIL ovf_fifo_intact: got %h expected %h", d, 32'h0000_0403); end
    apply_reset();
    $display("test_overflow done");
  endtask

  task automatic test_div_zero();
    logic [31:0] d;
    int lows;
    bus_write(A_BD, 32'hABCD_0003);
    bus_read(A_BD, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL bauddiv_upper_bits: got %h expected %h", d, 32'h3); end
    bus_write(A_BD, 32'h0);
    bus_read(A_BD, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL bauddiv_zero: got %h expected %h", d, 32'h1); end
    bus_write(A_TX, 32'hFF);
    @(posedge clk); #1;
    n_checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL div1_start: got tx=%b busy=%b expected tx=0 busy=1", tx, tx_busy); end
    lows = 0;
    for (int t = 1; t < 10; t++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL div1_body: got %0d bad cycles expected 0", lows); end
    @(posedge clk); #1;
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL div1_end: got tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy); end
    $display("test_div_zero done");
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int active;
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'h55);
    bus_write(A_TX, 32'hAA);
    // Frame started at edge k+1; data bit 3 spans edges k+17..k+20.
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_bit3: got tx=%b busy=%b expected tx=0 busy=1", tx, tx_busy); end
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h0000_0201) begin n_fail++; $display("FAIL midframe_queued: got %h expected %h", d, 32'h0000_0201); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_line: got tx=%b busy=%b expected tx=1 busy=0", tx, tx_busy); end
    bus_read(A_ST, d);
    n_checks++; if (d !== 32'h0000_0004) begin n_fail++; $display("FAIL midreset_status: got %h expected %h", d, 32'h4); end
    bus_read(A_BD, d);
    n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL midreset_bauddiv: got %h expected %h", d, 32'h10); end
    @(negedge clk); reset = 1'b0;
    active = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0) active++;
    end
    n_checks++; if (active !== 0) begin n_fail++; $display("FAIL midreset_no_frame: got %0d active cycles expected 0", active); end
    $display("test_reset_midframe done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    WE       = 1'b0;
    Adr      = 32'h0;
    WD       = 32'h0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_div_zero();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within budget");
    $fatal(1, "timeout");
  end

endmodule
